muldiv_ctrl: RTL and testbench

- Sequencing controller for the EX-stage multiplier and iterative divider, and the HI/LO write source.
- Accepts one mul/div/mthi/mtlo operation per EX instruction and drives the divider start/ready handshake.
- Counts multiplier latency, raises the EX stall request while an operation is in flight, and emits HI/LO write enables with data.
- Sits between the EX decode fields and the mul/div units; the stall request feeds the pipeline stall controller.

---
 rtl/muldiv_ctrl_pkg.sv | 36 +++
 rtl/muldiv_ctrl_if.sv | 42 ++++
 rtl/muldiv_ctrl_lat_cnt.sv | 27 ++
 rtl/muldiv_ctrl.sv | 163 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: encodings shared by the mul/div sequencing controller,
// the pipeline stall controller and the iterative divider.
package muldiv_ctrl_pkg;

  // EX-stage operation selector for the HI/LO unit
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_type_e;

  // Controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    MUL_RUN = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Stall request levels understood by the stall controller
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Divider start handshake levels
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  // Only MULT and DIV treat their operands as two's complement
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX decode fields, divider/multiplier handshake and HI/LO
// write port of the mul/div sequencing controller.
interface muldiv_ctrl_if;
  logic        flush;
  logic        op_valid;
  logic [2:0]  op_type;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        div_ready_i;
  logic [63:0] div_result_i;
  logic [63:0] mul_result_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        mul_signed_o;
  logic [31:0] mul_ina_o;
  logic [31:0] mul_inb_o;
  logic        stallreq_o;
  logic        hi_we_o;
  logic        lo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;

  modport slave (
    input  flush, op_valid, op_type, opa, opb,
    input  div_ready_i, div_result_i, mul_result_i,
    output div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o,
    output mul_signed_o, mul_ina_o, mul_inb_o,
    output stallreq_o, hi_we_o, lo_we_o, hi_o, lo_o, busy_o
  );

  modport master (
    output flush, op_valid, op_type, opa, opb,
    output div_ready_i, div_result_i, mul_result_i,
    input  div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o,
    input  mul_signed_o, mul_ina_o, mul_inb_o,
    input  stallreq_o, hi_we_o, lo_we_o, hi_o, lo_o, busy_o
  );
endinterface

// File: rtl/muldiv_ctrl_lat_cnt.sv
// muldiv_lat_cnt: loadable down-counter that times the multiplier latency.
module muldiv_lat_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load takes priority over decrement; the count saturates at zero
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one mul/div/mthi/mtlo per EX instruction, holds the
// pipeline while a multiply or divide is in flight and writes HI/LO.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = 4
) (
  input logic          clk,
  input logic          rst,
  muldiv_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_e      state, state_nxt;
  logic [31:0] hi_r, lo_r;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic        cap_div, cap_mul;
  logic        div_start, div_annul, div_signed, mul_signed, stallreq;
  logic [31:0] div_op1, div_op2, mul_a, mul_b;
  logic        hi_we, lo_we;
  logic [31:0] hi_data, lo_data;

  muldiv_lat_cnt #(.CNT_W(CNT_W)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (MUL_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // HI/LO result capture from whichever unit finishes
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (cap_div) begin
      {hi_r, lo_r} <= bus.div_result_i;
    end else if (cap_mul) begin
      {hi_r, lo_r} <= bus.mul_result_i;
    end
  end

  // Next state and all handshake/write outputs; reset and flush silence everything
  always_comb begin
    state_nxt  = state;
    div_start  = DIV_STOP;
    div_annul  = 1'b0;
    div_signed = 1'b0;
    div_op1    = '0;
    div_op2    = '0;
    mul_signed = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    stallreq   = NO_STOP;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_data    = '0;
    lo_data    = '0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cap_div    = 1'b0;
    cap_mul    = 1'b0;
    if (rst) begin
      state_nxt = IDLE;
    end else if (bus.flush) begin
      state_nxt = IDLE;
      div_annul = (state == DIV_RUN);
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            case (bus.op_type)
              OP_DIV, OP_DIVU: begin
                div_start  = DIV_START;
                div_signed = is_signed_op(bus.op_type);
                div_op1    = bus.opa;
                div_op2    = bus.opb;
                stallreq   = STOP;
                state_nxt  = DIV_RUN;
              end
              OP_MULT, OP_MULTU: begin
                mul_signed = is_signed_op(bus.op_type);
                mul_a      = bus.opa;
                mul_b      = bus.opb;
                stallreq   = STOP;
                cnt_load   = 1'b1;
                state_nxt  = MUL_RUN;
              end
              OP_MTHI: begin
                hi_we   = 1'b1;
                hi_data = bus.opa;
              end
              OP_MTLO: begin
                lo_we   = 1'b1;
                lo_data = bus.opa;
              end
              default: ;
            endcase
          end
        end
        DIV_RUN: begin
          div_signed = is_signed_op(bus.op_type);
          div_op1    = bus.opa;
          div_op2    = bus.opb;
          stallreq   = STOP;
          if (bus.div_ready_i) begin
            cap_div   = 1'b1;
            state_nxt = DONE;
          end else begin
            div_start = DIV_START;
          end
        end
        MUL_RUN: begin
          mul_signed = is_signed_op(bus.op_type);
          mul_a      = bus.opa;
          mul_b      = bus.opb;
          stallreq   = STOP;
          if (cnt_zero) begin
            cap_mul   = 1'b1;
            state_nxt = DONE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        DONE: begin
          hi_we     = 1'b1;
          lo_we     = 1'b1;
          hi_data   = hi_r;
          lo_data   = lo_r;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.div_start_o   = div_start;
  assign bus.div_annul_o   = div_annul;
  assign bus.div_signed_o  = div_signed;
  assign bus.div_opdata1_o = div_op1;
  assign bus.div_opdata2_o = div_op2;
  assign bus.mul_signed_o  = mul_signed;
  assign bus.mul_ina_o     = mul_a;
  assign bus.mul_inb_o     = mul_b;
  assign bus.stallreq_o    = stallreq;
  assign bus.hi_we_o       = hi_we;
  assign bus.lo_we_o       = lo_we;
  assign bus.hi_o          = hi_data;
  assign bus.lo_o          = lo_data;
  assign bus.busy_o        = !rst && (state != IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scenario tasks around muldiv_ctrl with behavioural
// divider/multiplier models and an arithmetic HI/LO reference.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MUL_CYCLES = 2;

  logic clk = 1'b0;
  logic rst;
  muldiv_ctrl_if bus();

  muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int div_lat = 33;
  int mon_starts = 0, mon_hi_w = 0, mon_lo_w = 0, mon_annul = 0, mon_stall = 0;
  logic prev_start = 1'b0;
  logic f_stall, f_start, f_mul_sgn, f_div_sgn;
  logic [31:0] f_mul_a, f_mul_b, f_div_a, f_div_b;
  logic d_hi_we, d_lo_we;
  logic [31:0] d_hi, d_lo;

  // Reference: 64-bit product of two 32-bit operands
  function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Reference: {remainder, quotient}; divide by zero yields {dividend, all ones}
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    sa = $signed(a);
    sb = $signed(b);
    if (sb == -1) begin
      q = 32'd0 - a;
      r = 32'd0;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
    return {r, q};
  endfunction

  // Divider model: result valid div_lat cycles after start is first seen
  int div_cnt = 0;
  always @(posedge clk) begin
    if (rst || bus.div_annul_o === 1'b1 || bus.div_start_o !== 1'b1) begin
      div_cnt <= 0;
      bus.div_ready_i <= 1'b0;
      bus.div_result_i <= 64'd0;
    end else if (bus.div_ready_i) begin
      bus.div_ready_i <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1;
      if (div_cnt + 1 >= div_lat) begin
        bus.div_ready_i <= 1'b1;
        bus.div_result_i <= ref_div(bus.div_signed_o, bus.div_opdata1_o, bus.div_opdata2_o);
      end
    end
  end

  // Multiplier model: MUL_CYCLES-deep product pipeline
  logic [63:0] mul_pipe [MUL_CYCLES];
  always @(posedge clk) begin
    mul_pipe[0] <= ref_mul(bus.mul_signed_o, bus.mul_ina_o, bus.mul_inb_o);
    for (int i = 1; i < MUL_CYCLES; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign bus.mul_result_i = mul_pipe[MUL_CYCLES-1];

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.div_start_o === 1'b1 && prev_start !== 1'b1) mon_starts++;
    prev_start = bus.div_start_o;
    if (bus.hi_we_o === 1'b1) mon_hi_w++;
    if (bus.lo_we_o === 1'b1) mon_lo_w++;
    if (bus.div_annul_o === 1'b1) mon_annul++;
    if (bus.stallreq_o === 1'b1) mon_stall++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_edge();
      bus.op_valid = 1'b0;
      bus.flush = 1'b0;
      tick();
    end
  endtask

  // Present one instruction and hold it until the stall request drops
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int budget, output int stalls, output bit done);
    next_edge();
    bus.op_valid = 1'b1;
    bus.op_type = op;
    bus.opa = a;
    bus.opb = b;
    stalls = 0;
    done = 1'b0;
    tick();
    f_stall = bus.stallreq_o;
    f_start = bus.div_start_o;
    f_mul_sgn = bus.mul_signed_o;
    f_div_sgn = bus.div_signed_o;
    f_mul_a = bus.mul_ina_o;
    f_mul_b = bus.mul_inb_o;
    f_div_a = bus.div_opdata1_o;
    f_div_b = bus.div_opdata2_o;
    for (int i = 0; i < budget; i++) begin
      if (bus.stallreq_o !== 1'b1) begin
        done = 1'b1;
        break;
      end
      stalls++;
      next_edge();
      tick();
    end
    d_hi_we = bus.hi_we_o;
    d_lo_we = bus.lo_we_o;
    d_hi = bus.hi_o;
    d_lo = bus.lo_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.op_valid = 1'b1;
    bus.op_type = OP_DIV;
    bus.opa = $urandom;
    bus.opb = $urandom;
    tick();
    tick();
    checks++; if (bus.div_start_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_div_start: got %b want 0", bus.div_start_o); end
    checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall: got %b want 0", bus.stallreq_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b want 0", bus.busy_o); end
    checks++; if ({bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.lo_o} !== 66'd0) begin errors++; $display("[TB] FAIL rst_hilo: got we=%b%b hi=%h lo=%h want all 0", bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.lo_o); end
    checks++; if ({bus.div_opdata1_o, bus.mul_ina_o, bus.div_signed_o} !== 65'd0) begin errors++; $display("[TB] FAIL rst_operands: got div=%h mul=%h want 0", bus.div_opdata1_o, bus.mul_ina_o); end
    next_edge();
    rst = 1'b0;
    bus.op_valid = 1'b0;
    tick();
    checks++; if (bus.busy_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_release: got busy=%b stall=%b want 0 0", bus.busy_o, bus.stallreq_o); end
  endtask

  task automatic test_div_fixed();
    int stalls, s0, h0, l0;
    bit done;
    logic [63:0] exp;
    div_lat = 33;
    s0 = mon_starts; h0 = mon_hi_w; l0 = mon_lo_w;
    exp = ref_div(1'b1, 32'd100, 32'd7);
    run_op(OP_DIV, 32'd100, 32'd7, 200, stalls, done);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL div_done: got %b want 1 (timeout)", done); end
    checks++; if (f_div_sgn !== 1'b1 || f_start !== 1'b1) begin errors++; $display("[TB] FAIL div_issue: got signed=%b start=%b want 1 1", f_div_sgn, f_start); end
    checks++; if (f_div_a !== 32'd100 || f_div_b !== 32'd7) begin errors++; $display("[TB] FAIL div_operands: got %0d/%0d want 100/7", f_div_a, f_div_b); end
    checks++; if (stalls !== 34) begin errors++; $display("[TB] FAIL div_stall: got %0d want 34", stalls); end
    checks++; if (d_hi_we !== 1'b1 || d_lo_we !== 1'b1) begin errors++; $display("[TB] FAIL div_we: got %b%b want 11", d_hi_we, d_lo_we); end
    checks++; if (d_hi !== exp[63:32] || d_hi !== 32'd2) begin errors++; $display("[TB] FAIL div_hi: got %h want 2", d_hi); end
    checks++; if (d_lo !== exp[31:0] || d_lo !== 32'd14) begin errors++; $display("[TB] FAIL div_lo: got %h want e", d_lo); end
    idle(3);
    checks++; if (mon_hi_w - h0 !== 1 || mon_lo_w - l0 !== 1) begin errors++; $display("[TB] FAIL div_write_count: got %0d/%0d want 1/1", mon_hi_w - h0, mon_lo_w - l0); end
    checks++; if (mon_starts - s0 !== 1) begin errors++; $display("[TB] FAIL div_start_count: got %0d want 1", mon_starts - s0); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL div_idle_busy: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_mult_fixed();
    int stalls;
    bit done;
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 50, stalls, done);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL mult_done: got %b want 1 (timeout)", done); end
    checks++; if (f_mul_sgn !== 1'b1 || f_mul_a !== 32'hFFFF_FFFE || f_mul_b !== 32'd3) begin errors++; $display("[TB] FAIL mult_issue: got sgn=%b a=%h b=%h want 1 fffffffe 3", f_mul_sgn, f_mul_a, f_mul_b); end
    checks++; if (stalls !== MUL_CYCLES + 1) begin errors++; $display("[TB] FAIL mult_stall: got %0d want %0d", stalls, MUL_CYCLES + 1); end
    checks++; if (d_hi_we !== 1'b1 || d_lo_we !== 1'b1) begin errors++; $display("[TB] FAIL mult_we: got %b%b want 11", d_hi_we, d_lo_we); end
    checks++; if (d_hi !== 32'hFFFF_FFFF || d_lo !== 32'hFFFF_FFFA) begin errors++; $display("[TB] FAIL mult_data: got %h_%h want ffffffff_fffffffa", d_hi, d_lo); end
    idle(1);
  endtask

  task automatic test_random_ops();
    int stalls, exp_stall;
    bit done;
    logic [2:0] op;
    logic [31:0] a, b;
    logic [63:0] exp;
    logic sgn;
    for (int n = 0; n < 10; n++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 4) == 0) b = 32'd0;
      if (n == 0) begin op = OP_DIVU; b = 32'd0; end
      div_lat = $urandom_range(1, 20);
      sgn = (op == OP_MULT) || (op == OP_DIV);
      exp = (op <= OP_MULTU) ? ref_mul(sgn, a, b) : ref_div(sgn, a, b);
      exp_stall = (op <= OP_MULTU) ? MUL_CYCLES + 1 : div_lat + 1;
      run_op(op, a, b, 100, stalls, done);
      checks++; if (done !== 1'b1 || stalls !== exp_stall) begin errors++; $display("[TB] FAIL rand_stall op=%0d: got %0d done=%b want %0d", op, stalls, done, exp_stall); end
      checks++; if (((op <= OP_MULTU) ? f_mul_sgn : f_div_sgn) !== sgn) begin errors++; $display("[TB] FAIL rand_signed op=%0d: got mul=%b div=%b want %b", op, f_mul_sgn, f_div_sgn, sgn); end
      checks++; if (d_hi_we !== 1'b1 || d_lo_we !== 1'b1 || {d_hi, d_lo} !== exp) begin errors++; $display("[TB] FAIL rand_data op=%0d a=%h b=%h: got we=%b%b %h_%h want %h", op, a, b, d_hi_we, d_lo_we, d_hi, d_lo, exp); end
      idle(1);
    end
  endtask

  task automatic test_mthi_mtlo();
    int stalls, st0, h0, l0;
    bit done;
    st0 = mon_stall; h0 = mon_hi_w; l0 = mon_lo_w;
    run_op(OP_MTHI, 32'h1234_5678, $urandom, 4, stalls, done);
    checks++; if (done !== 1'b1 || stalls !== 0) begin errors++; $display("[TB] FAIL mthi_stall: got %0d want 0", stalls); end
    checks++; if (d_hi_we !== 1'b1 || d_lo_we !== 1'b0 || d_hi !== 32'h1234_5678) begin errors++; $display("[TB] FAIL mthi_write: got we=%b%b hi=%h want 10 12345678", d_hi_we, d_lo_we, d_hi); end
    run_op(OP_MTLO, 32'hCAFE_BABE, $urandom, 4, stalls, done);
    checks++; if (d_lo_we !== 1'b1 || d_hi_we !== 1'b0 || d_lo !== 32'hCAFE_BABE) begin errors++; $display("[TB] FAIL mtlo_write: got we=%b%b lo=%h want 01 cafebabe", d_hi_we, d_lo_we, d_lo); end
    run_op(3'd6, $urandom, $urandom, 4, stalls, done);
    checks++; if ({d_hi_we, d_lo_we, f_start, f_stall} !== 4'b0000) begin errors++; $display("[TB] FAIL noop_quiet: got we=%b%b start=%b stall=%b want 0000", d_hi_we, d_lo_we, f_start, f_stall); end
    idle(2);
    checks++; if (mon_hi_w - h0 !== 1 || mon_lo_w - l0 !== 1 || mon_stall - st0 !== 0) begin errors++; $display("[TB] FAIL move_counts: got hi=%0d lo=%0d stall=%0d want 1 1 0", mon_hi_w - h0, mon_lo_w - l0, mon_stall - st0); end
  endtask

  task automatic test_flush();
    int h0, l0, a0;
    h0 = mon_hi_w; l0 = mon_lo_w; a0 = mon_annul;
    div_lat = 33;
    next_edge();
    bus.op_valid = 1'b1; bus.op_type = OP_DIVU; bus.opa = $urandom; bus.opb = $urandom_range(1, 1000);
    tick();
    for (int k = 1; k <= 4; k++) begin next_edge(); tick(); end
    next_edge();
    bus.flush = 1'b1;
    tick();
    checks++; if (bus.div_annul_o !== 1'b1 || bus.stallreq_o !== 1'b0 || bus.div_start_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_div: got annul=%b stall=%b start=%b want 1 0 0", bus.div_annul_o, bus.stallreq_o, bus.div_start_o); end
    next_edge();
    bus.flush = 1'b0; bus.op_valid = 1'b0;
    tick();
    checks++; if (bus.busy_o !== 1'b0 || bus.div_annul_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle: got busy=%b annul=%b stall=%b want 0 0 0", bus.busy_o, bus.div_annul_o, bus.stallreq_o); end
    // flush landing on the DONE cycle of a multiply
    next_edge();
    bus.op_valid = 1'b1; bus.op_type = OP_MULTU; bus.opa = $urandom; bus.opb = $urandom;
    tick();
    for (int k = 1; k <= MUL_CYCLES; k++) begin next_edge(); tick(); end
    next_edge();
    bus.flush = 1'b1;
    tick();
    checks++; if (bus.busy_o !== 1'b1 || bus.hi_we_o !== 1'b0 || bus.lo_we_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_done: got busy=%b we=%b%b want 1 00", bus.busy_o, bus.hi_we_o, bus.lo_we_o); end
    idle(3);
    checks++; if (mon_hi_w - h0 !== 0 || mon_lo_w - l0 !== 0 || mon_annul - a0 !== 1) begin errors++; $display("[TB] FAIL flush_counts: got hi=%0d lo=%0d annul=%0d want 0 0 1", mon_hi_w - h0, mon_lo_w - l0, mon_annul - a0); end
  endtask

  task automatic test_reset_mid_mul();
    int stalls;
    bit done;
    next_edge();
    bus.op_valid = 1'b1; bus.op_type = OP_MULT; bus.opa = $urandom; bus.opb = $urandom;
    tick();
    next_edge();
    tick();
    next_edge();
    rst = 1'b1;
    tick();
    checks++; if ({bus.stallreq_o, bus.busy_o, bus.hi_we_o, bus.lo_we_o, bus.mul_signed_o, bus.mul_ina_o} !== 37'd0) begin errors++; $display("[TB] FAIL rstmul_outputs: got stall=%b busy=%b we=%b%b ina=%h want all 0", bus.stallreq_o, bus.busy_o, bus.hi_we_o, bus.lo_we_o, bus.mul_ina_o); end
    next_edge();
    rst = 1'b0; bus.op_valid = 1'b0;
    tick();
    checks++; if (bus.busy_o !== 1'b0 || bus.stallreq_o !== 1'b0 || bus.hi_we_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmul_idle: got busy=%b stall=%b hi_we=%b want 0 0 0", bus.busy_o, bus.stallreq_o, bus.hi_we_o); end
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 50, stalls, done);
    checks++; if (done !== 1'b1 || d_hi !== 32'd1 || d_lo !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL rstmul_fresh: got %h_%h want 00000001_fffffffe", d_hi, d_lo); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int stalls, s0, h0, l0;
    bit done;
    logic [31:0] a, b;
    div_lat = 10;
    s0 = mon_starts; h0 = mon_hi_w; l0 = mon_lo_w;
    run_op(OP_DIVU, $urandom, $urandom_range(1, 500), 100, stalls, done);
    checks++; if (done !== 1'b1 || stalls !== div_lat + 1) begin errors++; $display("[TB] FAIL b2b_first: got %0d want %0d", stalls, div_lat + 1); end
    a = $urandom; b = $urandom;
    run_op(OP_DIVU, a, b, 100, stalls, done);
    checks++; if (done !== 1'b1 || {d_hi, d_lo} !== ref_div(1'b0, a, b)) begin errors++; $display("[TB] FAIL b2b_second: got %h_%h want %h", d_hi, d_lo, ref_div(1'b0, a, b)); end
    idle(3);
    checks++; if (mon_starts - s0 !== 2 || mon_hi_w - h0 !== 2 || mon_lo_w - l0 !== 2) begin errors++; $display("[TB] FAIL b2b_counts: got starts=%0d hi=%0d lo=%0d want 2 2 2", mon_starts - s0, mon_hi_w - h0, mon_lo_w - l0); end
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_type = 3'd0;
    bus.opa = 32'd0;
    bus.opb = 32'd0;
    test_reset();
    test_div_fixed();
    test_mult_fixed();
    test_mthi_mtlo();
    test_random_ops();
    test_flush();
    test_reset_mid_mul();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
